annul_survivor_serializer: RTL and testbench



---
 rtl/annul_survivor_serializer_pkg.sv | 21 ++
 rtl/Annuller.sv | 20 ++
 rtl/survivor_select.sv | 59 +++++
 rtl/annul_survivor_serializer.sv | 81 ++++++++
 tb/tb_annul_survivor_serializer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/annul_survivor_serializer_pkg.sv
// Shared helpers for the survivor serializer: index-width derivation and word slicing.
// Packed-bus convention: word i lives at bits [i*WORD_WIDTH +: WORD_WIDTH].
package annul_survivor_serializer_pkg;

    // Ceiling log2, floored at 1 bit so a 2-word batch still gets an index bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int word_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/Annuller.sv
// Forces a word to zero when annul is high; combinational, no backpressure involvement.
// "AND" masks the data bits, any other implementation uses a mux.
module Annuller #(
    parameter int    WORD_WIDTH     = 8,
    parameter string IMPLEMENTATION = "AND"
) (
    input  logic                  annul,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out
);

    generate
        if (IMPLEMENTATION == "AND") begin : g_and
            assign data_out = data_in & {WORD_WIDTH{~annul}};
        end else begin : g_mux
            assign data_out = annul ? '0 : data_in;
        end
    endgenerate

endmodule

// File: rtl/survivor_select.sv
// Picks the lowest pending survivor: one-hot, index, is-last flag and the annulled-OR word.
// Purely combinational; zero latency, no handshake of its own.
module survivor_select
    import annul_survivor_serializer_pkg::*;
#(
    parameter  int WORD_WIDTH  = 8,
    parameter  int INPUT_COUNT = 4,
    localparam int INDEX_WIDTH = clog2(INPUT_COUNT)
) (
    input  logic [INPUT_COUNT-1:0]            i_mask,
    input  logic [INPUT_COUNT*WORD_WIDTH-1:0] i_words,
    output logic [INPUT_COUNT-1:0]            o_onehot,
    output logic [INDEX_WIDTH-1:0]            o_index,
    output logic                              o_is_last,
    output logic [WORD_WIDTH-1:0]             o_word
);

    logic [WORD_WIDTH-1:0] w_annulled [INPUT_COUNT];
    logic [WORD_WIDTH-1:0] w_word_or;
    logic [INDEX_WIDTH-1:0] w_index;

    // Two's-complement trick isolates the lowest set bit.
    assign o_onehot  = i_mask & ((~i_mask) + INPUT_COUNT'(1));
    assign o_is_last = (i_mask != '0) && ((i_mask & (i_mask - INPUT_COUNT'(1))) == '0);

    always_comb begin
        w_index = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            if (o_onehot[i]) begin
                w_index = INDEX_WIDTH'(i);
            end
        end
    end
    assign o_index = w_index;

    // Every word except the selected one is annulled, so an OR merges to the selection.
    genvar g;
    generate
        for (g = 0; g < INPUT_COUNT; g++) begin : g_annul
            Annuller #(
                .WORD_WIDTH     (WORD_WIDTH),
                .IMPLEMENTATION ("AND")
            ) u_annuller (
                .annul    (~o_onehot[g]),
                .data_in  (i_words[word_lsb(g, WORD_WIDTH) +: WORD_WIDTH]),
                .data_out (w_annulled[g])
            );
        end
    endgenerate

    always_comb begin
        w_word_or = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            w_word_or = w_word_or | w_annulled[i];
        end
    end
    assign o_word = w_word_or;

endmodule

// File: rtl/annul_survivor_serializer.sv
// Serializes the surviving words of a batch in ascending index order, one per handshake.
// Latency 1 cycle from accept; output held stable under backpressure, new batch accepted on the last handshake.
module annul_survivor_serializer
    import annul_survivor_serializer_pkg::*;
#(
    parameter  int WORD_WIDTH  = 8,
    parameter  int INPUT_COUNT = 4,
    localparam int INDEX_WIDTH = clog2(INPUT_COUNT)
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INPUT_COUNT-1:0]            in_survivors,
    input  logic [INPUT_COUNT*WORD_WIDTH-1:0] in_words,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WORD_WIDTH-1:0]             out_data,
    output logic [INDEX_WIDTH-1:0]            out_index,
    output logic                              out_last
);

    logic [INPUT_COUNT-1:0]            r_mask;
    logic [INPUT_COUNT*WORD_WIDTH-1:0] r_words;

    logic [INPUT_COUNT-1:0] w_onehot;
    logic [INDEX_WIDTH-1:0] w_sel_index;
    logic                   w_sel_last;
    logic [WORD_WIDTH-1:0]  w_sel_word;
    logic                   w_busy;
    logic                   w_out_hs;
    logic                   w_accept;

    survivor_select #(
        .WORD_WIDTH  (WORD_WIDTH),
        .INPUT_COUNT (INPUT_COUNT)
    ) u_select (
        .i_mask    (r_mask),
        .i_words   (r_words),
        .o_onehot  (w_onehot),
        .o_index   (w_sel_index),
        .o_is_last (w_sel_last),
        .o_word    (w_sel_word)
    );

    assign w_busy    = |r_mask;
    assign out_valid = w_busy;
    assign w_out_hs  = out_valid && out_ready;

    // Ready on the final handshake too, so consecutive batches run without a bubble.
    assign in_ready = !flush && (!w_busy || (w_out_hs && w_sel_last));
    assign w_accept = in_valid && in_ready;

    Annuller #(
        .WORD_WIDTH     (WORD_WIDTH),
        .IMPLEMENTATION ("AND")
    ) u_out_annul (
        .annul    (!out_valid),
        .data_in  (w_sel_word),
        .data_out (out_data)
    );

    assign out_index = out_valid ? w_sel_index : '0;
    assign out_last  = out_valid && w_sel_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mask  <= '0;
            r_words <= '0;
        end else if (flush) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask  <= in_survivors;
            r_words <= in_words;
        end else if (w_out_hs) begin
            r_mask <= r_mask & ~w_onehot;
        end
    end

endmodule

// File: tb/tb_annul_survivor_serializer.sv
// Randomized scoreboard bench for annul_survivor_serializer (WORD_WIDTH=8, INPUT_COUNT=4).
// Predictor queues expected survivors per accepted batch; a separate monitor pops on each output handshake.
module tb_annul_survivor_serializer;

    localparam int W = 8;
    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic [N-1:0]   in_survivors = '0;
    logic [N*W-1:0] in_words = '0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_index;
    logic           out_last;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
        logic       last;
    } item_t;

    item_t exp_q[$];
    int    pending = 0;
    int    tests = 0;
    int    fails = 0;
    bit    done = 1'b0;

    annul_survivor_serializer #(
        .WORD_WIDTH  (W),
        .INPUT_COUNT (N)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_survivors (in_survivors),
        .in_words     (in_words),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Survivors come out lowest index first; only the highest surviving index is last.
    function automatic void push_batch(input logic [N-1:0] s, input logic [N*W-1:0] w);
        int    hi;
        item_t t;
        hi = -1;
        for (int i = 0; i < N; i++) if (s[i]) hi = i;
        for (int i = 0; i < N; i++) begin
            if (s[i]) begin
                t.d    = w[i*W +: W];
                t.idx  = 2'(i);
                t.last = (i == hi);
                exp_q.push_back(t);
            end
        end
    endfunction

    // Monitor: checks what the DUT presents against the head of the queue.
    always @(negedge clock) begin
        if (!done && reset_n) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].d});
                chk("out_index", {30'd0, out_index}, {30'd0, exp_q[0].idx});
                chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
                if (out_ready) void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("idle_data", {24'd0, out_data}, 32'd0);
                chk("idle_index", {30'd0, out_index}, 32'd0);
                chk("idle_last", {31'd0, out_last}, 32'd0);
            end
        end
    end

    // Predictor: tracks outstanding survivors of the current batch and predicts accepts.
    always @(negedge clock) begin
        bit hs;
        bit rdy;
        #1;
        if (!reset_n) begin
            exp_q.delete();
            pending = 0;
        end else if (!done) begin
            hs  = (pending > 0) && out_ready;
            rdy = !flush && (pending == 0 || (hs && pending == 1));
            chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
            if (flush) begin
                pending = 0;
                exp_q.delete();
            end else if (in_valid && rdy) begin
                pending = $countones(in_survivors);
                push_batch(in_survivors, in_words);
            end else if (hs) begin
                pending--;
            end
        end
    end

    task automatic step(input bit v, input logic [N-1:0] s, input logic [N*W-1:0] w,
                        input bit ordy, input bit fl);
        in_valid     = v;
        in_survivors = s;
        in_words     = w;
        out_ready    = ordy;
        flush        = fl;
        @(posedge clock);
        #3;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        int k;
        @(posedge clock);
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_index", {30'd0, out_index}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b1;

        // Basic sequence
        step(1'b1, 4'b1010, 32'h44332211, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Backpressure for 3 cycles, then drain
        step(1'b1, 4'b1010, 32'h44332211, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Back-to-back batches
        step(1'b1, 4'b0001, 32'h000000AA, 1'b1, 1'b0);
        step(1'b1, 4'b1000, 32'hBB000000, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Empty batch then all survivors
        step(1'b1, 4'b0000, 32'h12345678, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b1, 4'b1111, 32'h44332211, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Flush after the first handshake
        step(1'b1, 4'b0111, 32'h00332211, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Async reset mid-batch, between edges
        step(1'b1, 4'b1111, 32'hDDCCBBAA, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_data", {24'd0, out_data}, 32'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        idle(3, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        // Bounded drain
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
            k++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        idle(2, 1'b1);

        done = 1'b1;
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
